// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional per-requester grant counters: define ALU_SHARE_ARBITER_STAT_EN.
module alu_share_arbiter #(
  parameter int W = 32
`ifdef ALU_SHARE_ARBITER_STAT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op0,
  output logic         gnt0,
  output logic         done0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   op1,
  output logic         gnt1,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_c
`ifdef ALU_SHARE_ARBITER_STAT_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  // state | meaning
  // IDLE  | waiting for a request; winner's operands latched on exit
  // EXEC  | ALU evaluating latched operands; gnt pulse to owner
  // DONE  | result register valid; done pulse to owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [W-1:0] result_q, result_d;
  logic         win;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    // On a tie the requester that did not win last time goes next.
    win      = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = EXEC;
          owner_d  = win;
          last_d   = win;
          alu_a_d  = win ? a1 : a0;
          alu_b_d  = win ? b1 : b0;
          alu_op_d = win ? op1 : op0;
        end
      end
      EXEC: begin
        result_d = alu_c;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
    end
  end

  assign gnt0   = (state_q == EXEC) && !owner_q;
  assign gnt1   = (state_q == EXEC) &&  owner_q;
  assign done0  = (state_q == DONE) && !owner_q;
  assign done1  = (state_q == DONE) &&  owner_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

`ifdef ALU_SHARE_ARBITER_STAT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Saturating grant counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU model.
// Counter checks are compiled in when ALU_SHARE_ARBITER_STAT_EN is defined.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]   op0 = '0, op1 = '0;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result, alu_a, alu_b, alu_c;
  logic [2:0]   alu_op;
`ifdef ALU_SHARE_ARBITER_STAT_EN
  logic [1:0]   cnt0, cnt1;
`endif

  typedef struct {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_c = alu_f(alu_a, alu_b, alu_op);

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .W(W)
`ifdef ALU_SHARE_ARBITER_STAT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1), .done1(done1),
    .result(result), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
`ifdef ALU_SHARE_ARBITER_STAT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
    exp_t e;
    e.id  = id;
    e.res = alu_f(a, b, op);
    sb.push_back(e);
  endtask

  // Advance one cycle, sample just after the edge, retire any done against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if ((gnt0 && gnt1) || (done0 && done1) || ((gnt0 || gnt1) && (done0 || done1)))
      check_val("pulse_excl", 1, 0);
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        check_val("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("done_id", 64'(done1), 64'(e.id));
        check_val("done_result", 64'(result), 64'(e.res));
      end
    end
  endtask

  initial begin
    int gcnt;
    int last_t;
    int idx;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic [2:0]   bb_op[3];
    bb_a  = '{32'd20, 32'hFFFF0000, 32'h00001234};
    bb_b  = '{32'd22, 32'h00FF00FF, 32'h00001234};
    bb_op = '{3'd1, 3'd3, 3'd4};

    // Reset held with both requests high.
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'd11; b0 = 32'd12; op0 = 3'd2;
    req1 = 1'b1; a1 = 32'd13; b1 = 32'd14; op1 = 3'd3;
    tick();
    tick();
    check_val("rst_gnt0", 64'(gnt0), 0);
    check_val("rst_gnt1", 64'(gnt1), 0);
    check_val("rst_done0", 64'(done0), 0);
    check_val("rst_done1", 64'(done1), 0);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_result", 64'(result), 0);
    check_val("rst_alu_a", 64'(alu_a), 0);
    check_val("rst_alu_b", 64'(alu_b), 0);
    check_val("rst_alu_op", 64'(alu_op), 0);
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check_val("idle_busy", 64'(busy), 0);

    // Single op from requester 0.
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 3'd0;
    push_exp(1'b0, a0, b0, op0);
    tick();
    check_val("single_gnt0", 64'(gnt0), 1);
    check_val("single_busy1", 64'(busy), 1);
    req0 = 1'b0; a0 = $urandom; b0 = $urandom;
    tick();
    check_val("single_done0", 64'(done0), 1);
    check_val("single_busy2", 64'(busy), 1);
    tick();
    check_val("single_busy3", 64'(busy), 0);
    tick();
    check_val("result_hold", 64'(result), 64'd8);

    // Tie after reset: grants alternate starting with requester 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; op0 = 3'd0;
    req1 = 1'b1; a1 = 32'd7; b1 = 32'd9; op1 = 3'd0;
    for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? a1 : a0, k[0] ? b1 : b0, 3'd0);
    gcnt = 0; last_t = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (gnt0 || gnt1) begin
        check_val("tie_order", 64'(gnt1), 64'(gcnt % 2));
        if (gcnt > 0) check_val("tie_spacing", 64'(t - last_t), 3);
        last_t = t;
        gcnt++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_val("tie_count", 64'(gcnt), 4);
    tick();
    check_val("tie_idle", 64'(busy), 0);

    // Requester 1 alone, back-to-back, new operands after each grant.
    idx = 0;
    req1 = 1'b1; a1 = bb_a[0]; b1 = bb_b[0]; op1 = bb_op[0];
    push_exp(1'b1, a1, b1, op1);
    gcnt = 0; last_t = 0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (gnt0) check_val("b2b_gnt0", 64'(gnt0), 0);
      if (gnt1) begin
        if (gcnt > 0) check_val("b2b_spacing", 64'(t - last_t), 3);
        last_t = t;
        gcnt++;
        if (idx < 2) begin
          idx++;
          a1 = bb_a[idx]; b1 = bb_b[idx]; op1 = bb_op[idx];
          push_exp(1'b1, a1, b1, op1);
        end
      end
    end
    req1 = 1'b0;
    check_val("b2b_count", 64'(gcnt), 3);

    // Reset during EXEC drops the op.
    tick();
    req0 = 1'b1; a0 = 32'd100; b0 = 32'd1; op0 = 3'd0;
    tick();
    check_val("mid_gnt0", 64'(gnt0), 1);
    reset = 1'b0; req0 = 1'b0;
    tick();
    check_val("mid_done0", 64'(done0), 0);
    check_val("mid_busy", 64'(busy), 0);
    check_val("mid_result", 64'(result), 0);
    check_val("mid_alu_a", 64'(alu_a), 0);
    reset = 1'b1;
    req0 = 1'b1; a0 = 32'd3; b0 = 32'd4; op0 = 3'd0;
    req1 = 1'b1; a1 = 32'd9; b1 = 32'd2; op1 = 3'd1;
    push_exp(1'b0, a0, b0, op0);
    push_exp(1'b1, a1, b1, op1);
    tick();
    check_val("post_rst_gnt0", 64'(gnt0), 1);
    check_val("post_rst_gnt1", 64'(gnt1), 0);
    for (int t = 2; t <= 6; t++) tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

`ifdef ALU_SHARE_ARBITER_STAT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_val("cnt0_rst", 64'(cnt0), 0);
    check_val("cnt1_rst", 64'(cnt1), 0);
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 3'd0;
    for (int k = 0; k < 5; k++) push_exp(1'b0, a0, b0, op0);
    for (int t = 1; t <= 15; t++) tick();
    req0 = 1'b0;
    req1 = 1'b1; a1 = 32'd6; b1 = 32'd3; op1 = 3'd2;
    for (int k = 0; k < 2; k++) push_exp(1'b1, a1, b1, op1);
    for (int t = 1; t <= 6; t++) tick();
    req1 = 1'b0;
    tick();
    check_val("cnt0_sat", 64'(cnt0), 3);
    check_val("cnt1_val", 64'(cnt1), 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_val("cnt0_clr", 64'(cnt0), 0);
    check_val("cnt1_clr", 64'(cnt1), 0);
`endif

    check_val("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (inputs A, B, ALUOp[2:0]; output C) between two requesters.
- Round-robin arbitration, registered ALU operands and registered result, with a simple req/done handshake per requester.
- Sits between the requesters and the ALU instance; the ALU is instantiated by the parent and wired to the alu_* ports.

Parameters:
- W, 32, operand/result width; must match the ALU width.
- CNT_W, 16, width of the per-requester grant counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- req0  in  1  requester 0 request (level)
- a0  in  W  requester 0 operand A
- b0  in  W  requester 0 operand B
- op0  in  3  requester 0 ALUOp, passed through opaquely
- gnt0  out  1  one-cycle pulse: requester 0 operation accepted
- done0  out  1  one-cycle pulse: requester 0 result valid
- req1, a1, b1, op1, gnt1, done1  same as requester 0, for requester 1
- result  out  W  registered ALU result
- busy  out  1  high while state != IDLE
- alu_a  out  W  to ALU A
- alu_b  out  W  to ALU B
- alu_op  out  3  to ALU ALUOp
- alu_c  in  W  from ALU C

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; gnt*, done*, busy = 0.
  - alu_a, alu_b, alu_op, result = 0.
  - last=1, so requester 0 wins the first tie.
  - Any in-flight operation is dropped, and no done is issued for it.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, req seen: pick a winner.
  - Only one req high: that requester wins.
  - Both high: the requester != last wins.
  - At the edge: latch the winner's a/b/op into alu_a/alu_b/alu_op, set owner=winner, last=winner, go to EXEC.
- EXEC (one cycle): gnt[owner]=1, busy=1. At the edge, result<=alu_c, go to DONE.
- DONE (one cycle): done[owner]=1, busy=1, result valid. Go to IDLE unconditionally.
- Latency: req sampled at edge t -> gnt high in cycle t+1 -> done and result in cycle t+2 -> IDLE in cycle t+3. Peak throughput is one op per 3 cycles.
- Requester rules:
  - Hold req/a/b/op stable from assertion until its gnt.
  - After gnt, operand values are don't-care.
  - A req still high when IDLE is re-entered is a new request; back-to-back ops are legal.
- Holding values:
  - result holds its value until the next DONE.
  - alu_a/alu_b/alu_op hold their last values between ops.
- Requests arriving during EXEC/DONE are ignored until IDLE (no queueing).
- Arithmetic: no width changes; alu_c is captured verbatim.
- Only one of gnt0/gnt1 and one of done0/done1 is ever high; gnt and done are never high in the same cycle.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STAT_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 [CNT_W-1:0].
  - Each counter increments on its gnt pulse and saturates at all-ones.
  - Both counters clear on reset.
- Undefined: the ports and logic do not exist.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req0=req1=1 -> gnt*, done*, busy = 0; result=0; alu_a/alu_b/alu_op=0.
- Single op (bench ALU model returns A+B for op 3'b000): req0=1, a0=5, b0=3, op0=0 at edge t -> gnt0=1 at t+1; done0=1 at t+2 with result=8; busy high only in t+1..t+2.
- Tie after reset: req0 and req1 held high for 12 cycles -> grant order 0,1,0,1; gnt pulses spaced 3 cycles apart; each done matches its own operands (a0=1,b0=1 -> 2; a1=7,b1=9 -> 16).
- Same requester back-to-back: req1 held alone with last=1 -> req1 re-granted every 3 cycles; no starvation, no bubble beyond 3.
- Reset mid-op: reset=0 during EXEC -> no done in the following cycle; state IDLE; result=0; next tie is won by requester 0.
- Stats (macro defined, CNT_W=2): 5 grants to req0 and 2 to req1 -> cnt0=3 (saturated), cnt1=2; reset -> both 0.
